// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback controller for the CR16 core.
// Outputs are decoded from the registered state, the latched instruction class and the live inputs.
//
// state     | meaning
// FETCH     | instruction read at PC, IR captured on ready
// DECODE    | latch instruction class, dispatch
// EXECUTE   | ALU result / branch / jump-and-link
// MEM       | data read or write at register operand address
// WRITEBACK | load data written to register file
// HALT      | sticky fault, left only through reset
module instr_sequencer #(
  parameter int unsigned P_MEM_TIMEOUT = 15,
  parameter int unsigned P_TIMER_WIDTH = 4
) (
  input  logic       I_CLK,
  input  logic       I_RESET,
  input  logic       I_ENABLE,
  input  logic [2:0] I_INSTR_CLASS,
  input  logic       I_BRANCH_TAKEN,
  input  logic       I_MEM_READY,
  output logic       O_PC_ENABLE,
  output logic       O_PC_ADDRESS_SELECT,
  output logic       O_IR_LOAD,
  output logic       O_MEM_REQ,
  output logic       O_MEM_WRITE,
  output logic       O_ADDR_SOURCE,
  output logic       O_REG_WRITE,
  output logic       O_HALT,
  output logic [2:0] O_STATE
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [2:0] C_ALU    = 3'd0;
  localparam logic [2:0] C_LOAD   = 3'd1;
  localparam logic [2:0] C_STORE  = 3'd2;
  localparam logic [2:0] C_BRANCH = 3'd3;
  localparam logic [2:0] C_JUMP   = 3'd4;
  localparam logic [2:0] C_NOP    = 3'd5;

  localparam logic [P_TIMER_WIDTH-1:0] TIMEOUT_C = P_TIMER_WIDTH'(P_MEM_TIMEOUT);
  localparam bit TIMEOUT_EN = (P_MEM_TIMEOUT != 0);

  state_t                   state_q, state_d;
  logic [2:0]               class_q;
  logic [P_TIMER_WIDTH-1:0] wait_cnt_q, wait_inc;
  logic                     active, timeout_hit;

  assign active      = I_ENABLE && !I_RESET;
  assign wait_inc    = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
  assign timeout_hit = TIMEOUT_EN && (wait_inc >= TIMEOUT_C);

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q    <= S_FETCH;
      class_q    <= C_ALU;
      wait_cnt_q <= '0;
    end else if (I_ENABLE) begin
      state_q <= state_d;
      if (state_q == S_DECODE) class_q <= I_INSTR_CLASS;
      // Counter restarts on every state change so each request gets a full budget.
      if ((state_d != state_q) || (O_MEM_REQ && I_MEM_READY)) wait_cnt_q <= '0;
      else if (O_MEM_REQ)                                     wait_cnt_q <= wait_inc;
    end
  end

  always_comb begin
    state_d             = state_q;
    O_PC_ENABLE         = 1'b0;
    O_PC_ADDRESS_SELECT = 1'b0;
    O_IR_LOAD           = 1'b0;
    O_MEM_REQ           = 1'b0;
    O_MEM_WRITE         = 1'b0;
    O_ADDR_SOURCE       = 1'b0;
    O_REG_WRITE         = 1'b0;
    case (state_q)
      S_FETCH: if (active) begin
        O_MEM_REQ = 1'b1;
        if (I_MEM_READY) begin
          O_IR_LOAD = 1'b1;
          state_d   = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_HALT;
        end
      end
      S_DECODE: if (active) begin
        case (I_INSTR_CLASS)
          C_ALU, C_BRANCH, C_JUMP: state_d = S_EXECUTE;
          C_LOAD, C_STORE:         state_d = S_MEM;
          C_NOP: begin
            O_PC_ENABLE = 1'b1;
            state_d     = S_FETCH;
          end
          default:                 state_d = S_HALT;
        endcase
      end
      S_EXECUTE: if (active) begin
        O_PC_ENABLE = 1'b1;
        case (class_q)
          C_ALU:    O_REG_WRITE = 1'b1;
          C_BRANCH: O_PC_ADDRESS_SELECT = I_BRANCH_TAKEN;
          C_JUMP: begin
            O_REG_WRITE         = 1'b1;
            O_PC_ADDRESS_SELECT = 1'b1;
          end
          default: ;
        endcase
        state_d = S_FETCH;
      end
      S_MEM: if (active) begin
        O_MEM_REQ     = 1'b1;
        O_ADDR_SOURCE = 1'b1;
        O_MEM_WRITE   = (class_q == C_STORE);
        if (I_MEM_READY) begin
          if (class_q == C_STORE) begin
            O_PC_ENABLE = 1'b1;
            state_d     = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (timeout_hit) begin
          state_d = S_HALT;
        end
      end
      S_WRITEBACK: if (active) begin
        O_REG_WRITE = 1'b1;
        O_PC_ENABLE = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  assign O_HALT  = (state_q == S_HALT) && !I_RESET;
  assign O_STATE = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-cycle vector table plus hand-written
// sequences for halt, memory timeout, reset mid-store and enable freeze.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [2:0] cls = 3'd0;
  logic       tk = 1'b0;
  logic       rdy = 1'b0;
  logic       pc_en, pc_sel, ir_load, mem_req, mem_wr, addr_src, reg_wr, halt;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_sequencer #(.P_MEM_TIMEOUT(15), .P_TIMER_WIDTH(4)) dut (
    .I_CLK(clk), .I_RESET(rst), .I_ENABLE(en), .I_INSTR_CLASS(cls),
    .I_BRANCH_TAKEN(tk), .I_MEM_READY(rdy),
    .O_PC_ENABLE(pc_en), .O_PC_ADDRESS_SELECT(pc_sel), .O_IR_LOAD(ir_load),
    .O_MEM_REQ(mem_req), .O_MEM_WRITE(mem_wr), .O_ADDR_SOURCE(addr_src),
    .O_REG_WRITE(reg_wr), .O_HALT(halt), .O_STATE(state)
  );

  // strobe vector order: {pc_en, pc_sel, ir_load, mem_req, mem_wr, addr_src, reg_wr}
  localparam logic [6:0] NONE   = 7'b0000000;
  localparam logic [6:0] F_RDY  = 7'b0011000;
  localparam logic [6:0] F_WAIT = 7'b0001000;
  localparam logic [6:0] EX_ALU = 7'b1000001;
  localparam logic [6:0] LD_MEM = 7'b0001010;
  localparam logic [6:0] ST_MEM = 7'b0001110;
  localparam logic [6:0] ST_RDY = 7'b1001110;
  localparam logic [6:0] WB     = 7'b1000001;
  localparam logic [6:0] BR_T   = 7'b1100000;
  localparam logic [6:0] PC_INC = 7'b1000000;
  localparam logic [6:0] JMP    = 7'b1100001;

  typedef struct {
    logic       rst, en;
    logic [2:0] cls;
    logic       tk, rdy;
    logic [2:0] st;
    logic [6:0] strb;
    logic       hlt;
  } vec_t;

  vec_t tbl[$];

  task automatic cyc(input logic r, input logic e, input logic [2:0] c, input logic t,
                     input logic y, input logic [2:0] es, input logic [6:0] eo,
                     input logic eh, input string nm);
    logic [6:0] got;
    @(negedge clk);
    rst = r; en = e; cls = c; tk = t; rdy = y;
    #1;
    got = {pc_en, pc_sel, ir_load, mem_req, mem_wr, addr_src, reg_wr};
    checks++;
    if (state !== es || got !== eo || halt !== eh) begin
      failures++;
      $display("FAIL %s: got state=%0d strobes=%b halt=%b, expected state=%0d strobes=%b halt=%b",
               nm, state, got, halt, es, eo, eh);
    end
  endtask

  initial begin
    // reset (overrides enable low), then ALU x3
    tbl.push_back('{1, 0, 0, 0, 1, 0, NONE, 0});
    for (int k = 0; k < 3; k++) begin
      tbl.push_back('{0, 1, 0, 0, 1, 0, F_RDY, 0});
      tbl.push_back('{0, 1, 0, 0, 1, 1, NONE, 0});
      tbl.push_back('{0, 1, 0, 0, 1, 2, EX_ALU, 0});
    end
    // LOAD with two wait cycles in MEM
    tbl.push_back('{0, 1, 0, 0, 1, 0, F_RDY, 0});
    tbl.push_back('{0, 1, 1, 0, 1, 1, NONE, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 3, LD_MEM, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 3, LD_MEM, 0});
    tbl.push_back('{0, 1, 0, 0, 1, 3, LD_MEM, 0});
    tbl.push_back('{0, 1, 0, 0, 1, 4, WB, 0});
    // BRANCH taken, then not taken; class input changed during EXECUTE
    tbl.push_back('{0, 1, 0, 0, 1, 0, F_RDY, 0});
    tbl.push_back('{0, 1, 3, 0, 1, 1, NONE, 0});
    tbl.push_back('{0, 1, 0, 1, 1, 2, BR_T, 0});
    tbl.push_back('{0, 1, 0, 0, 1, 0, F_RDY, 0});
    tbl.push_back('{0, 1, 3, 1, 1, 1, NONE, 0});
    tbl.push_back('{0, 1, 0, 0, 1, 2, PC_INC, 0});
    // JUMP and link
    tbl.push_back('{0, 1, 0, 0, 1, 0, F_RDY, 0});
    tbl.push_back('{0, 1, 4, 0, 1, 1, NONE, 0});
    tbl.push_back('{0, 1, 0, 0, 1, 2, JMP, 0});
    // NOP
    tbl.push_back('{0, 1, 0, 0, 1, 0, F_RDY, 0});
    tbl.push_back('{0, 1, 5, 0, 1, 1, PC_INC, 0});
    // zero-wait STORE
    tbl.push_back('{0, 1, 0, 0, 1, 0, F_RDY, 0});
    tbl.push_back('{0, 1, 2, 0, 1, 1, NONE, 0});
    tbl.push_back('{0, 1, 0, 0, 1, 3, ST_RDY, 0});
    // FETCH wait, enable low in FETCH, then ALU with EXECUTE frozen 4 cycles
    tbl.push_back('{0, 1, 0, 0, 0, 0, F_WAIT, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 0, NONE, 0});
    tbl.push_back('{0, 1, 0, 0, 1, 0, F_RDY, 0});
    tbl.push_back('{0, 1, 0, 0, 1, 1, NONE, 0});
    for (int k = 0; k < 4; k++) tbl.push_back('{0, 0, 0, 0, 1, 2, NONE, 0});
    tbl.push_back('{0, 1, 0, 0, 1, 2, EX_ALU, 0});
    tbl.push_back('{0, 1, 0, 0, 1, 0, F_RDY, 0});

    foreach (tbl[i])
      cyc(tbl[i].rst, tbl[i].en, tbl[i].cls, tbl[i].tk, tbl[i].rdy,
          tbl[i].st, tbl[i].strb, tbl[i].hlt, $sformatf("vec%0d", i));

    // illegal class -> HALT, sticky for 20 cycles even with enable toggling
    cyc(0, 1, 6, 0, 1, 1, NONE, 0, "illegal_decode");
    for (int k = 0; k < 20; k++)
      cyc(0, (k % 4) != 0, 0, 0, 1, 5, NONE, 1, $sformatf("halt_hold%0d", k));
    cyc(1, 1, 0, 0, 1, 5, NONE, 0, "halt_reset_cycle");

    // FETCH timeout: 15 wait cycles then HALT
    for (int k = 1; k <= 15; k++)
      cyc(0, 1, 0, 0, 0, 0, F_WAIT, 0, $sformatf("fetch_wait%0d", k));
    cyc(0, 1, 0, 0, 0, 5, NONE, 1, "fetch_timeout_halt");
    cyc(1, 1, 0, 0, 0, 5, NONE, 0, "timeout_reset_cycle");

    // ready arriving in the 15th cycle wins over the timeout
    for (int k = 1; k <= 14; k++)
      cyc(0, 1, 0, 0, 0, 0, F_WAIT, 0, $sformatf("fetch_wait_b%0d", k));
    cyc(0, 1, 0, 0, 1, 0, F_RDY, 0, "ready_at_15");
    cyc(0, 1, 0, 0, 1, 1, NONE, 0, "decode_after_15");
    cyc(0, 1, 0, 0, 1, 2, EX_ALU, 0, "exec_after_15");

    // reset in MEM during a STORE: no write, FETCH next
    cyc(0, 1, 0, 0, 1, 0, F_RDY, 0, "st_fetch");
    cyc(0, 1, 2, 0, 1, 1, NONE, 0, "st_decode");
    cyc(0, 1, 0, 0, 0, 3, ST_MEM, 0, "st_mem_wait");
    cyc(1, 1, 0, 0, 1, 3, NONE, 0, "st_reset_cycle");
    cyc(0, 1, 0, 0, 0, 0, F_WAIT, 0, "st_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
